// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: control, redirect, instruction-memory and decode-side signals of the fetch stage.
interface pc_fetch_unit_if #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 32
);
  logic                   stall;
  logic                   stall_pm;
  logic                   jump_en;
  logic [PC_WIDTH-1:0]    jump_addr;
  logic                   branch_en;
  logic [15:0]            branch_off;
  logic [INSTR_WIDTH-1:0] imem_data;
  logic [PC_WIDTH-1:0]    pc;
  logic [INSTR_WIDTH-1:0] ir_out;
  logic                   ir_valid;
  logic                   halted;
  modport master (
    output stall, stall_pm, jump_en, jump_addr, branch_en, branch_off, imem_data,
    input  pc, ir_out, ir_valid, halted
  );
  modport slave (
    input  stall, stall_pm, jump_en, jump_addr, branch_en, branch_off, imem_data,
    output pc, ir_out, ir_valid, halted
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter, fetch/decode instruction register and sticky halt detection.
module pc_fetch_unit #(
  parameter int PC_WIDTH    = 8,
  parameter int INSTR_WIDTH = 32,
  parameter int RESET_VEC   = 0,
  parameter int HALT_LIMIT  = 4
) (
  input logic            clk,
  input logic            reset,
  pc_fetch_unit_if.slave bus
);
  typedef enum logic [1:0] {RUN, HOLD, HALT} state_t;
  localparam logic [3:0] CNT_LAST = 4'(HALT_LIMIT - 1);
  state_t                 r_state;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [INSTR_WIDTH-1:0] r_ir;
  logic                   r_valid;
  logic                   r_halted;
  logic [3:0]             r_stall_cnt;
  logic                   w_redirect;
  logic                   w_squash;
  logic                   w_halt;
  logic [PC_WIDTH-1:0]    w_off;
  logic [PC_WIDTH-1:0]    w_next_pc;
  assign w_halt     = r_state == HALT;
  assign w_redirect = bus.jump_en | bus.branch_en;
  assign w_squash   = w_halt | bus.stall_pm | w_redirect | bus.stall;
  assign w_off      = PC_WIDTH'($signed(bus.branch_off));
  // Redirects outrank stall: the stall block raises stall in the same cycle a jump decodes.
  assign w_next_pc  = w_halt        ? r_pc :
                      bus.jump_en   ? bus.jump_addr :
                      bus.branch_en ? r_pc + PC_WIDTH'(1) + w_off :
                      bus.stall     ? r_pc :
                                      r_pc + PC_WIDTH'(1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= RUN;
      r_pc        <= PC_WIDTH'(RESET_VEC);
      r_ir        <= '0;
      r_valid     <= 1'b0;
      r_halted    <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_pc    <= w_next_pc;
      r_ir    <= w_squash ? '0 : bus.imem_data;
      r_valid <= ~w_squash;
      if (!w_halt)
        r_stall_cnt <= (bus.stall & ~w_redirect) ?
                       ((r_stall_cnt == 4'hF) ? r_stall_cnt : r_stall_cnt + 4'd1) : 4'd0;
      case (r_state)
        RUN:  if (bus.stall & ~w_redirect) r_state <= HOLD;
        HOLD: if (w_redirect | ~bus.stall) r_state <= RUN;
              else if (r_stall_cnt == CNT_LAST) begin
                r_state  <= HALT;
                r_halted <= 1'b1;
              end
        default: r_state <= HALT;
      endcase
    end
  end
  assign bus.pc       = r_pc;
  assign bus.ir_out   = r_ir;
  assign bus.ir_valid = r_valid;
  assign bus.halted   = r_halted;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed vectors for the fetch stage with hand-computed expectations.
module tb_pc_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  pc_fetch_unit_if #(.PC_WIDTH(8), .INSTR_WIDTH(32)) bus ();
  pc_fetch_unit #(.PC_WIDTH(8), .INSTR_WIDTH(32), .RESET_VEC(0), .HALT_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  assign bus.imem_data = 32'h100 + 32'(bus.pc);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic look(input string tag, input logic [7:0] p, input logic [31:0] ir, input logic v);
    check({tag, ".pc"}, 32'(bus.pc), 32'(p));
    check({tag, ".ir"}, bus.ir_out, ir);
    check({tag, ".valid"}, 32'(bus.ir_valid), 32'(v));
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.stall = 0; bus.stall_pm = 0; bus.jump_en = 0; bus.jump_addr = '0;
    bus.branch_en = 0; bus.branch_off = '0;
  endtask
  initial begin
    idle();
    #2;
    look("reset", 8'h00, 0, 0);
    check("reset.halted", 32'(bus.halted), 0);
    @(negedge clk) reset = 0;
    for (int i = 1; i <= 4; i++) begin
      step();
      look("run", 8'(i), 32'h100 + 32'(i - 1), 1);
    end
    bus.stall = 1;
    step(); look("stall", 8'h04, 0, 0);
    bus.stall = 0; bus.stall_pm = 1;
    step(); look("stall_pm", 8'h05, 0, 0);
    bus.stall_pm = 0;
    step(); look("resume", 8'h06, 32'h105, 1);
    check("resume.halted", 32'(bus.halted), 0);
    step(); look("run7", 8'h07, 32'h106, 1);
    bus.jump_en = 1; bus.jump_addr = 8'h40; bus.stall = 1;
    step(); look("jump", 8'h40, 0, 0);
    idle();
    step(); look("jump_fetch", 8'h41, 32'h140, 1);
    #3; bus.jump_en = 1; bus.jump_addr = 8'h77; reset = 1;
    #1; look("async_rst", 8'h00, 0, 0);
    @(negedge clk); idle(); reset = 0;
    step(); look("post_rst", 8'h01, 32'h100, 1);
    bus.branch_en = 1; bus.branch_off = 16'hFFFE;
    step(); look("branch_neg", 8'h00, 0, 0);
    idle(); bus.jump_en = 1; bus.jump_addr = 8'h20; bus.branch_en = 1; bus.branch_off = 16'd5;
    step(); look("jump_beats_br", 8'h20, 0, 0);
    idle(); bus.branch_en = 1; bus.branch_off = 16'd3;
    step(); look("branch_pos", 8'h24, 0, 0);
    idle(); bus.jump_en = 1; bus.jump_addr = 8'hFF;
    step(); look("jump_ff", 8'hFF, 0, 0);
    idle();
    step(); look("wrap", 8'h00, 32'h1FF, 1);
    bus.branch_en = 1; bus.branch_off = 16'hFFFC;
    step(); look("branch_wrap", 8'hFD, 0, 0);
    idle(); bus.stall = 1;
    repeat (3) step();
    check("hold3.halted", 32'(bus.halted), 0);
    bus.jump_en = 1; bus.jump_addr = 8'h09;
    step(); look("jump_in_hold", 8'h09, 0, 0);
    bus.jump_en = 0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("hlt%0d.halted", i), 32'(bus.halted), 32'(i == 4));
      look($sformatf("hlt%0d", i), 8'h09, 0, 0);
    end
    idle(); bus.jump_en = 1; bus.jump_addr = 8'h33;
    step(); look("halt_jump", 8'h09, 0, 0);
    check("halt_jump.halted", 32'(bus.halted), 1);
    idle();
    step(); look("halt_idle", 8'h09, 0, 0);
    #2; reset = 1;
    #1; look("halt_rst", 8'h00, 0, 0);
    check("halt_rst.halted", 32'(bus.halted), 0);
    @(negedge clk) reset = 0;
    step(); look("restart", 8'h01, 32'h100, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
